// File: rtl/axil_sram_pkg.sv
// Shared bus widths, AXI response codes and FSM state encodings for the
// AXI4-Lite SRAM responder.
package axil_sram_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } w_state_t;

endpackage

// File: rtl/axil_sram_bank.sv
// DEPTH x 32 storage with one synchronous read port and one byte-enabled
// synchronous write port; a same-edge read of a word being written sees the old value.
module sram_bank
    import axil_sram_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic              clk_i,
    input  logic              rd_en_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [STRB_W-1:0] wr_strb_i
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array and its read register are deliberately left without reset so
    // contents survive rst_i and the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb_i[b]) begin
                    mem[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
        if (rd_en_i) begin
            rd_data_o <= mem[rd_idx_i];
        end
    end

endmodule

// File: rtl/axil_sram.sv
// AXI4-Lite responder over on-chip word storage: independent read and write
// FSMs, one outstanding transaction each, fixed response latency.
module axil_sram
    import axil_sram_pkg::*;
#(
    parameter int               DEPTH   = 1024,
    parameter int               LATENCY = 1,
    parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] araddr_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [STRB_W-1:0] wstrb_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic [1:0]        bresp_o,
    output logic              bvalid_o,
    input  logic              bready_i
);

    localparam int              IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] SPAN  = {1'b0, ADDR_W'(DEPTH)} << 2;
    localparam logic [3:0]      LAT   = 4'(LATENCY);

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE;
        return (addr >= BASE) && ({1'b0, off} < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE;
        return IDX_W'(off >> 2);
    endfunction

    // Read channel
    r_state_t          r_state, r_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;
    logic [3:0]        r_cnt;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && arvalid_i) begin
                r_addr <= araddr_i;
                r_err  <= !in_range(araddr_i);
                r_cnt  <= LAT;
            end else if (r_state == R_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        r_next    = r_state;
        arready_o = 1'b0;
        rvalid_o  = 1'b0;
        rd_en     = 1'b0;
        rd_idx    = word_idx(r_addr);
        case (r_state)
            R_IDLE: begin
                arready_o = 1'b1;
                if (arvalid_i) begin
                    if (LAT == 4'd0) begin
                        rd_en  = 1'b1;
                        rd_idx = word_idx(araddr_i);
                        r_next = R_RESP;
                    end else begin
                        r_next = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt == 4'd1) begin
                    rd_en  = 1'b1;
                    r_next = R_RESP;
                end
            end
            R_RESP: begin
                rvalid_o = 1'b1;
                if (rready_i) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
        rdata_o = (rvalid_o && !r_err) ? rd_data : '0;
        rresp_o = (rvalid_o && r_err) ? RESP_SLVERR : RESP_OKAY;
    end

    // Write channel
    w_state_t          w_state, w_next;
    logic              aw_have, w_have;
    logic [ADDR_W-1:0] aw_addr, eff_addr;
    logic [DATA_W-1:0] w_data, eff_data;
    logic [STRB_W-1:0] w_strb, eff_strb;
    logic [3:0]        w_cnt;
    logic              b_err;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;

    // Beats arriving in the completing cycle are used directly so LATENCY=0 commits at once.
    assign eff_addr = aw_have ? aw_addr : awaddr_i;
    assign eff_data = w_have  ? w_data  : wdata_i;
    assign eff_strb = w_have  ? w_strb  : wstrb_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state <= W_IDLE;
            aw_have <= 1'b0;
            w_have  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            w_cnt   <= '0;
            b_err   <= 1'b0;
        end else begin
            w_state <= w_next;
            case (w_state)
                W_IDLE: begin
                    if (!aw_have && awvalid_i) begin
                        aw_have <= 1'b1;
                        aw_addr <= awaddr_i;
                    end
                    if (!w_have && wvalid_i) begin
                        w_have <= 1'b1;
                        w_data <= wdata_i;
                        w_strb <= wstrb_i;
                    end
                    if (w_next != W_IDLE) begin
                        b_err <= !in_range(eff_addr);
                        w_cnt <= LAT;
                    end
                end
                W_WAIT: w_cnt <= w_cnt - 4'd1;
                W_RESP: begin
                    if (bready_i) begin
                        aw_have <= 1'b0;
                        w_have  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = w_state;
        awready_o = 1'b0;
        wready_o  = 1'b0;
        bvalid_o  = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = word_idx(aw_addr);
        wr_data   = w_data;
        wr_strb   = w_strb;
        case (w_state)
            W_IDLE: begin
                awready_o = !aw_have;
                wready_o  = !w_have;
                if ((aw_have || awvalid_i) && (w_have || wvalid_i)) begin
                    if (LAT == 4'd0) begin
                        wr_en   = in_range(eff_addr);
                        wr_idx  = word_idx(eff_addr);
                        wr_data = eff_data;
                        wr_strb = eff_strb;
                        w_next  = W_RESP;
                    end else begin
                        w_next = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (w_cnt == 4'd1) begin
                    wr_en  = !b_err;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                bvalid_o = 1'b1;
                if (bready_i) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
        bresp_o = (bvalid_o && b_err) ? RESP_SLVERR : RESP_OKAY;
    end

    sram_bank #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk_i     (clk_i),
        .rd_en_i   (rd_en),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data),
        .wr_en_i   (wr_en),
        .wr_idx_i  (wr_idx),
        .wr_data_i (wr_data),
        .wr_strb_i (wr_strb)
    );

endmodule

// File: tb/tb_axil_sram.sv
// Directed bench for axil_sram: a vector table of single transactions plus
// hand-written sequences for ordering, backpressure, collision and reset.
module tb_axil_sram;
    import axil_sram_pkg::*;

    localparam int          DEPTH = 1024;
    localparam int          LAT   = 1;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          LIMIT = 50;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] araddr_i = '0;
    logic        arvalid_i = 1'b0;
    logic        arready_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rvalid_o;
    logic        rready_i = 1'b0;
    logic [31:0] awaddr_i = '0;
    logic        awvalid_i = 1'b0;
    logic        awready_o;
    logic [31:0] wdata_i = '0;
    logic [3:0]  wstrb_i = '0;
    logic        wvalid_i = 1'b0;
    logic        wready_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready_i = 1'b0;

    axil_sram #(.DEPTH(DEPTH), .LATENCY(LAT), .BASE(BASE)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called on a falling edge with the write FSM idle; lat counts rising edges
    // from the AW/W handshake edge (inclusive) until bvalid_o is seen.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int lat);
        awaddr_i = a; wdata_i = d; wstrb_i = s;
        awvalid_i = 1'b1; wvalid_i = 1'b1; bready_i = 1'b0;
        @(posedge clk_i); lat = 1;
        @(negedge clk_i);
        awvalid_i = 1'b0; wvalid_i = 1'b0;
        while (!bvalid_o && lat < LIMIT) begin
            @(posedge clk_i); lat++;
            @(negedge clk_i);
        end
        check("bvalid seen", 32'(bvalid_o), 32'd1);
        resp = bresp_o;
        bready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        bready_i = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] resp, output int lat);
        araddr_i = a; arvalid_i = 1'b1; rready_i = 1'b0;
        @(posedge clk_i); lat = 1;
        @(negedge clk_i);
        arvalid_i = 1'b0;
        while (!rvalid_o && lat < LIMIT) begin
            @(posedge clk_i); lat++;
            @(negedge clk_i);
        end
        check("rvalid seen", 32'(rvalid_o), 32'd1);
        d = rdata_o; resp = rresp_o;
        rready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rready_i = 1'b0;
    endtask

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;

        vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, RESP_OKAY,   32'h0};
        vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, RESP_OKAY,   32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, RESP_OKAY,   32'h0};
        vecs[3]  = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, RESP_OKAY,   32'h0};
        vecs[4]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, RESP_OKAY,   32'h11BB_33DD};
        vecs[5]  = '{1'b1, 32'h8000_0022, 32'hFFFF_FFFF, 4'h0, RESP_OKAY,   32'h0};
        vecs[6]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, RESP_OKAY,   32'h11BB_33DD};
        vecs[7]  = '{1'b1, 32'h8000_0000, 32'h0000_0A5A, 4'hF, RESP_OKAY,   32'h0};
        vecs[8]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, RESP_SLVERR, 32'h0};
        vecs[9]  = '{1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, RESP_SLVERR, 32'h0};
        vecs[10] = '{1'b0, 32'h8000_1000, 32'h0,         4'h0, RESP_SLVERR, 32'h0};
        vecs[11] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, RESP_OKAY,   32'h0000_0A5A};
        vecs[12] = '{1'b1, 32'h8000_0FFF, 32'hCAFE_F00D, 4'hF, RESP_OKAY,   32'h0};
        vecs[13] = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, RESP_OKAY,   32'hCAFE_F00D};

        // Reset values, sampled before the first rising edge
        #2;
        check("rst arready", 32'(arready_o), 32'd1);
        check("rst awready", 32'(awready_o), 32'd1);
        check("rst wready",  32'(wready_o),  32'd1);
        check("rst rvalid",  32'(rvalid_o),  32'd0);
        check("rst bvalid",  32'(bvalid_o),  32'd0);
        check("rst rdata",   rdata_o,        32'd0);
        check("rst rresp",   32'(rresp_o),   32'd0);
        check("rst bresp",   32'(bresp_o),   32'd0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r, lat);
                check($sformatf("v%0d bresp", i), 32'(r), 32'(vecs[i].resp));
                check($sformatf("v%0d b latency", i), 32'(lat), 32'(LAT + 1));
            end else begin
                axi_read(vecs[i].addr, d, r, lat);
                check($sformatf("v%0d rresp", i), 32'(r), 32'(vecs[i].resp));
                check($sformatf("v%0d rdata", i), d, vecs[i].rdata);
                check($sformatf("v%0d r latency", i), 32'(lat), 32'(LAT + 1));
            end
        end

        // W beat three cycles ahead of AW, then B held off for four cycles
        wdata_i = 32'h5555_AAAA; wstrb_i = 4'hF; wvalid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        wvalid_i = 1'b0;
        check("early W wready low", 32'(wready_o), 32'd0);
        check("early W awready",    32'(awready_o), 32'd1);
        check("early W no bvalid",  32'(bvalid_o), 32'd0);
        repeat (2) @(negedge clk_i);
        awaddr_i = 32'h8000_0040; awvalid_i = 1'b1;
        @(posedge clk_i); lat = 1;
        @(negedge clk_i);
        awvalid_i = 1'b0;
        while (!bvalid_o && lat < LIMIT) begin
            @(posedge clk_i); lat++;
            @(negedge clk_i);
        end
        check("late AW b latency", 32'(lat), 32'(LAT + 1));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check($sformatf("held bvalid %0d", k), 32'(bvalid_o), 32'd1);
            check($sformatf("held bresp %0d", k),  32'(bresp_o),  32'(RESP_OKAY));
        end
        bready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        bready_i = 1'b0;
        check("after B bvalid",  32'(bvalid_o),  32'd0);
        check("after B awready", 32'(awready_o), 32'd1);
        check("after B wready",  32'(wready_o),  32'd1);
        axi_read(32'h8000_0040, d, r, lat);
        check("late AW readback", d, 32'h5555_AAAA);

        // Read samples the word at the same edge the write commits: old data wins
        axi_write(32'h8000_0050, 32'h1, 4'hF, r, lat);
        araddr_i = 32'h8000_0050; arvalid_i = 1'b1;
        awaddr_i = 32'h8000_0050; awvalid_i = 1'b1;
        wdata_i = 32'h2; wstrb_i = 4'hF; wvalid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        arvalid_i = 1'b0; awvalid_i = 1'b0; wvalid_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("collision rvalid", 32'(rvalid_o), 32'd1);
        check("collision bvalid", 32'(bvalid_o), 32'd1);
        check("collision old data", rdata_o, 32'h1);
        rready_i = 1'b1; bready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rready_i = 1'b0; bready_i = 1'b0;
        axi_read(32'h8000_0050, d, r, lat);
        check("collision new data", d, 32'h2);

        // Asynchronous reset while the read FSM is waiting
        araddr_i = 32'h8000_0010; arvalid_i = 1'b1;
        @(posedge clk_i);
        #1;
        arvalid_i = 1'b0;
        check("in wait arready", 32'(arready_o), 32'd0);
        rst_i = 1'b1;
        #1;
        check("async rst arready", 32'(arready_o), 32'd1);
        check("async rst rvalid",  32'(rvalid_o),  32'd0);
        check("async rst rdata",   rdata_o,        32'd0);
        check("async rst rresp",   32'(rresp_o),   32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check($sformatf("dropped rvalid %0d", k), 32'(rvalid_o), 32'd0);
        end
        axi_read(32'h8000_0010, d, r, lat);
        check("survives reset data", d, 32'hDEAD_BEEF);
        check("survives reset resp", 32'(r), 32'(RESP_OKAY));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
